// File: rtl/phase_accum_mc.sv
// Multi-channel DDS phase accumulator: one shared adder sweeps all channels once per sample tick.
// Define PHASE_DITHER_EN to add LFSR dither below the published phase LSB before truncation.
module phase_accum_mc #(
  parameter int unsigned PHASE_W  = 16,
  parameter int unsigned OUT_W    = 10,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned TICK_DIV = 4,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      cfg_sel,
  input  logic [CH_W-1:0]           cfg_chan,
  input  logic [PHASE_W-1:0]        cfg_data,
  input  logic                      sync,
  output logic [CHANNELS*OUT_W-1:0] phase_out,
  output logic                      phase_valid,
  output logic [CHANNELS-1:0]       wrap,
  output logic                      busy
);

  localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DITH_W = PHASE_W - OUT_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PUB  = 2'd2;

  if (TICK_DIV < CHANNELS + 2) begin : g_bad_tick_div
    $error("phase_accum_mc: TICK_DIV must be >= CHANNELS+2");
  end
  if (OUT_W >= PHASE_W) begin : g_bad_out_w
    $error("phase_accum_mc: OUT_W must be < PHASE_W");
  end

  logic [1:0]                             state_q, state_d;
  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  logic [CH_W-1:0]                        ch_q, ch_d;
  logic [CHANNELS-1:0][PHASE_W-1:0]       acc_q, acc_d;
  logic [CHANNELS-1:0][PHASE_W-1:0]       ftw_sh_q, ftw_sh_d;
  logic [CHANNELS-1:0][PHASE_W-1:0]       off_sh_q, off_sh_d;
  logic [CHANNELS-1:0][PHASE_W-1:0]       ftw_act_q, ftw_act_d;
  logic [CHANNELS-1:0][PHASE_W-1:0]       off_act_q, off_act_d;
  logic [CHANNELS-1:0]                    wrap_nxt_q, wrap_nxt_d;
  logic [CHANNELS-1:0]                    wrap_q, wrap_d;
  logic [CHANNELS-1:0][OUT_W-1:0]         phase_out_q, phase_out_d;
  logic                                   phase_valid_q, phase_valid_d;
  logic                                   busy_q, busy_d;
  logic                                   cfg_ready_q, cfg_ready_d;
  logic                                   sync_pend_q, sync_pend_d;
  logic                                   sync_run_q, sync_run_d;

  logic                                   tick;
  logic                                   cfg_fire;
  logic [PHASE_W-1:0]                     sel_acc;
  logic [PHASE_W-1:0]                     sel_ftw;
  logic [PHASE_W:0]                       sum;
  logic [PHASE_W-1:0]                     pub_sum;

`ifdef PHASE_DITHER_EN
  logic [15:0]                            lfsr_q, lfsr_d;
  logic                                   lfsr_fb;
`endif

  assign tick     = en & (cnt_q == CNT_W'(TICK_DIV - 1));
  assign cfg_fire = cfg_valid & cfg_ready_q;

  // Sample-tick divider; en=0 freezes it but never stalls a sweep in flight
  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

`ifdef PHASE_DITHER_EN
  // Fibonacci LFSR, taps 16,14,13,11, stepped once per tick
  always_comb begin
    lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d  = tick ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;
  end
`endif

  // Sweep FSM, config shadow/active copies and publish
  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    acc_d         = acc_q;
    ftw_sh_d      = ftw_sh_q;
    off_sh_d      = off_sh_q;
    ftw_act_d     = ftw_act_q;
    off_act_d     = off_act_q;
    wrap_nxt_d    = wrap_nxt_q;
    wrap_d        = wrap_q;
    phase_out_d   = phase_out_q;
    phase_valid_d = 1'b0;
    sync_pend_d   = sync_pend_q | sync;
    sync_run_d    = sync_run_q;
    sel_acc       = '0;
    sel_ftw       = '0;
    sum           = '0;
    pub_sum       = '0;

    // Out-of-range channel numbers match nothing and are dropped
    if (cfg_fire) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (cfg_chan == CH_W'(c)) begin
          if (cfg_sel) off_sh_d[c] = cfg_data;
          else         ftw_sh_d[c] = cfg_data;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d     = S_RUN;
          ch_d        = '0;
          ftw_act_d   = ftw_sh_d;
          off_act_d   = off_sh_d;
          sync_run_d  = sync_pend_d;
          sync_pend_d = 1'b0;
          wrap_nxt_d  = '0;
        end
      end
      S_RUN: begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          if (ch_q == CH_W'(c)) begin
            sel_acc = sync_run_q ? '0 : acc_q[c];
            sel_ftw = ftw_act_q[c];
          end
        end
        sum = {1'b0, sel_acc} + {1'b0, sel_ftw};
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          if (ch_q == CH_W'(c)) begin
            acc_d[c]      = sum[PHASE_W-1:0];
            wrap_nxt_d[c] = sum[PHASE_W] & ~sync_run_q;
          end
        end
        // Last channel: outputs are registered on entry to PUB so they are valid during it
        if (ch_q == CH_W'(CHANNELS - 1)) begin
          state_d       = S_PUB;
          phase_valid_d = 1'b1;
          wrap_d        = wrap_nxt_d;
          sync_run_d    = 1'b0;
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            pub_sum = acc_d[c] + off_act_q[c];
`ifdef PHASE_DITHER_EN
            pub_sum = pub_sum + PHASE_W'(lfsr_q[DITH_W-1:0]);
`endif
            phase_out_d[c] = pub_sum[PHASE_W-1 -: OUT_W];
          end
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      S_PUB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d != S_IDLE);
    cfg_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ch_q          <= '0;
      acc_q         <= '0;
      ftw_sh_q      <= '0;
      off_sh_q      <= '0;
      ftw_act_q     <= '0;
      off_act_q     <= '0;
      wrap_nxt_q    <= '0;
      wrap_q        <= '0;
      phase_out_q   <= '0;
      phase_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      cfg_ready_q   <= 1'b0;
      sync_pend_q   <= 1'b0;
      sync_run_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ch_q          <= ch_d;
      acc_q         <= acc_d;
      ftw_sh_q      <= ftw_sh_d;
      off_sh_q      <= off_sh_d;
      ftw_act_q     <= ftw_act_d;
      off_act_q     <= off_act_d;
      wrap_nxt_q    <= wrap_nxt_d;
      wrap_q        <= wrap_d;
      phase_out_q   <= phase_out_d;
      phase_valid_q <= phase_valid_d;
      busy_q        <= busy_d;
      cfg_ready_q   <= cfg_ready_d;
      sync_pend_q   <= sync_pend_d;
      sync_run_q    <= sync_run_d;
    end
  end

`ifdef PHASE_DITHER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 16'hACE1;
    else      lfsr_q <= lfsr_d;
  end
`endif

  assign cfg_ready   = cfg_ready_q;
  assign phase_out   = phase_out_q;
  assign phase_valid = phase_valid_q;
  assign wrap        = wrap_q;
  assign busy        = busy_q;

endmodule
